// File: rtl/a2d_pkg.sv
// Shared types and constants for the round-robin A2D sampler.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    READ,
    UPD
  } a2d_state_t;

  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  localparam int unsigned RR_W = 2;

  // Round-robin slot to physical A2D channel.
  function automatic logic [2:0] rr_to_chnl(input logic [RR_W-1:0] rr);
    case (rr)
      2'd1:    return CH_RGHT;
      2'd2:    return CH_BATT;
      default: return CH_LFT;
    endcase
  endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Generic 16-bit SPI master: SCLK idles high, MISO sampled on SCLK rise,
// MOSI shifted on SCLK fall.
module spi_mstr16 #(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int unsigned CNT_W = $clog2(SCLK_DIV);
  localparam logic [CNT_W-1:0] FALL_PT = CNT_W'(SCLK_DIV / 2);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_nxt_c;
  logic [4:0]       rise_cnt;
  logic [15:0]      tx_shft;
  logic             rise_c;
  logic             fall_c;

  assign div_nxt_c = div_cnt + CNT_W'(1);
  assign rise_c    = ~SS_n && (div_nxt_c == '0);
  assign fall_c    = ~SS_n && (div_nxt_c == FALL_PT);
  assign MOSI      = tx_shft[15];

  // Divider is parked at zero while deselected so SS_n fall is cycle 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SS_n     <= 1'b1;
      SCLK     <= 1'b1;
      done     <= 1'b0;
      div_cnt  <= '0;
      rise_cnt <= '0;
      tx_shft  <= '0;
      rd_data  <= '0;
    end else begin
      done <= 1'b0;
      if (SS_n) begin
        div_cnt <= '0;
        if (wrt) begin
          SS_n     <= 1'b0;
          tx_shft  <= cmd;
          rise_cnt <= '0;
        end
      end else if (fall_c && (rise_cnt == 5'd16)) begin
        // Would-be 17th fall: deselect instead, leaving SCLK high.
        SS_n    <= 1'b1;
        done    <= 1'b1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_nxt_c;
        SCLK    <= ~div_nxt_c[CNT_W-1];
        if (rise_c) begin
          rd_data  <= {rd_data[14:0], MISO};
          rise_cnt <= rise_cnt + 5'd1;
        end
        if (fall_c && (rise_cnt != 5'd0)) begin
          tx_shft <= {tx_shft[14:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// Round-robin A2D sampler: one command/read SPI pair per nxt request,
// updating left load, right load or battery in turn.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int unsigned CNT_W = $clog2(SCLK_DIV);
  // GAP is entered one cycle after SS_n rises, so launch READ one count early.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SCLK_DIV - 2);

  a2d_state_t      state;
  a2d_state_t      next_state;
  logic [RR_W-1:0] rr;
  logic [CNT_W-1:0] gap_cnt;
  logic            wrt_c;
  logic [15:0]     cmd_c;
  logic            done;
  logic [15:0]     rd_data;
  logic            rd_unused_c;

  assign rd_unused_c = ^rd_data[15:12];

  spi_mstr16 #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt_c),
    .cmd     (cmd_c),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    wrt_c      = 1'b0;
    cmd_c      = '0;
    case (state)
      IDLE: begin
        if (nxt) begin
          wrt_c      = 1'b1;
          cmd_c      = {2'b00, rr_to_chnl(rr), 11'h000};
          next_state = CMD;
        end
      end
      CMD:  if (done) next_state = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          wrt_c      = 1'b1;
          next_state = READ;
        end
      end
      READ: if (done) next_state = UPD;
      UPD:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Deselect time between command and read transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               gap_cnt <= '0;
    else if (state == GAP) gap_cnt <= gap_cnt + CNT_W'(1);
    else                   gap_cnt <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_ld    <= '0;
      rght_ld   <= '0;
      batt      <= '0;
      cnv_cmplt <= 1'b0;
      rr        <= '0;
    end else begin
      cnv_cmplt <= (state == UPD);
      if (state == UPD) begin
        case (rr)
          2'd0:    lft_ld  <= rd_data[11:0];
          2'd1:    rght_ld <= rd_data[11:0];
          default: batt    <= rd_data[11:0];
        endcase
        rr <= (rr == 2'd2) ? '0 : rr + RR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf with a behavioural 8-channel A2D model.
module tb_a2d_intf;

  localparam int unsigned SCLK_DIV = 32;
  localparam int LAT = 1090;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic        MISO = 1'b1;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        cnv_cmplt, SS_n, SCLK, MOSI;

  always #5 clk = ~clk;

  a2d_intf #(.SCLK_DIV(SCLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .batt      (batt),
    .cnv_cmplt (cnv_cmplt),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct {
    int          sel;
    logic [11:0] val;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cmd_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @cyc %0d", name, act, req, cyc);
    end
  endtask

  // A2D model: channel latched from the command word, result returned
  // on the following transaction with a nonzero upper nibble.
  logic [11:0] ch_val [8];
  logic        prev_ss = 1'b1, prev_sclk = 1'b1, mdl_rd = 1'b0;
  logic [2:0]  mdl_ch = 3'd0;
  logic [15:0] mdl_word = 16'h0, mdl_rx = 16'h0;
  int          mdl_fall = 0;
  int          trans_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mdl_rd = 1'b0;
    end else begin
      if (prev_ss && !SS_n) begin
        mdl_fall = 0;
        mdl_rx   = 16'h0;
        mdl_word = mdl_rd ? {4'hD, ch_val[mdl_ch]} : 16'hBEEF;
        MISO     = mdl_word[15];
      end
      if (!SS_n && prev_sclk && !SCLK) begin
        if (mdl_fall > 0 && mdl_fall < 16) MISO = mdl_word[15-mdl_fall];
        mdl_fall++;
      end
      if (!SS_n && !prev_sclk && SCLK) mdl_rx = {mdl_rx[14:0], MOSI};
      if (!prev_ss && SS_n) begin
        trans_cnt++;
        if (!mdl_rd) begin
          mdl_ch = mdl_rx[13:11];
          if (exp_cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cmd actual=%h required=none", mdl_rx);
          end else begin
            chk("cmd_word", 32'(mdl_rx), 32'(exp_cmd_q.pop_front()));
          end
        end
        mdl_rd = !mdl_rd;
      end
    end
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  // Monitor: every cnv_cmplt pops one expectation and checks all results.
  logic [11:0] shadow [3];
  exp_t        mon_e;
  int          cnv_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      shadow[0] = 12'h0;
      shadow[1] = 12'h0;
      shadow[2] = 12'h0;
    end else if (cnv_cmplt) begin
      cnv_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cnv_cmplt actual=1 required=0 @cyc %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cnv_latency", 32'(cyc), 32'(mon_e.cyc));
        shadow[mon_e.sel] = mon_e.val;
        chk("lft_ld", 32'(lft_ld), 32'(shadow[0]));
        chk("rght_ld", 32'(rght_ld), 32'(shadow[1]));
        chk("batt", 32'(batt), 32'(shadow[2]));
      end
    end
  end

  task automatic issue(input int sel, input logic [11:0] val, input logic [15:0] cmdw);
    exp_t e;
    @(posedge clk); #1;
    nxt = 1'b1;
    exp_cmd_q.push_back(cmdw);
    e.sel = sel; e.val = val; e.cyc = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(posedge clk); #1;
    nxt = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_cmd_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    int base, t0, c0;
    for (int i = 0; i < 8; i++) ch_val[i] = 12'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_lft_ld", 32'(lft_ld), 32'h0);
    chk("rst_rght_ld", 32'(rght_ld), 32'h0);
    chk("rst_batt", 32'(batt), 32'h0);
    chk("rst_ss_n", 32'(SS_n), 32'h1);
    chk("rst_sclk", 32'(SCLK), 32'h1);
    chk("rst_cnv_cmplt", 32'(cnv_cmplt), 32'h0);
    chk("rst_mosi", 32'(MOSI), 32'h0);

    // Single conversion on channel 0
    ch_val[0] = 12'hA5C;
    ch_val[4] = 12'h3C1;
    ch_val[5] = 12'h7E2;
    issue(0, 12'hA5C, 16'h0000);
    drain(1500);
    chk("single_rght_untouched", 32'(rght_ld), 32'h0);
    chk("single_batt_untouched", 32'(batt), 32'h0);

    // Round robin from a fresh reset, fourth request wraps to lft_ld
    do_reset();
    chk("rr_rst_lft_ld", 32'(lft_ld), 32'h0);
    ch_val[0] = 12'h123;
    issue(0, 12'h123, 16'h0000); drain(1500);
    issue(1, 12'h3C1, 16'h2000); drain(1500);
    issue(2, 12'h7E2, 16'h2800); drain(1500);
    ch_val[0] = 12'h456;
    issue(0, 12'h456, 16'h0000); drain(1500);

    // nxt during READ is ignored
    t0 = trans_cnt;
    c0 = cnv_seen;
    issue(1, 12'h3C1, 16'h2000);
    repeat (700) @(posedge clk);
    #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    drain(1500);
    repeat (1200) @(posedge clk);
    #1;
    chk("busy_trans_count", 32'(trans_cnt - t0), 32'd2);
    chk("busy_cnv_count", 32'(cnv_seen - c0), 32'd1);

    // Held nxt: three back-to-back conversions, 1 cycle apart
    ch_val[5] = 12'h0FF;
    ch_val[0] = 12'h800;
    ch_val[4] = 12'h001;
    @(posedge clk); #1;
    nxt  = 1'b1;
    base = cyc + 1;
    e.sel = 2; e.val = 12'h0FF; e.cyc = base + 1090; exp_q.push_back(e);
    e.sel = 0; e.val = 12'h800; e.cyc = base + 2181; exp_q.push_back(e);
    e.sel = 1; e.val = 12'h001; e.cyc = base + 3272; exp_q.push_back(e);
    exp_cmd_q.push_back(16'h2800);
    exp_cmd_q.push_back(16'h0000);
    exp_cmd_q.push_back(16'h2000);
    repeat (2183) @(posedge clk);
    #1 nxt = 1'b0;
    drain(1500);

    // Abort mid-CMD with SCLK low; next command must be channel 0
    @(posedge clk); #1 nxt = 1'b1;
    @(posedge clk); #1 nxt = 1'b0;
    repeat (210) @(posedge clk);
    #1;
    chk("abort_ss_n_active", 32'(SS_n), 32'h0);
    chk("abort_sclk_low", 32'(SCLK), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("abort_ss_n_async", 32'(SS_n), 32'h1);
    chk("abort_sclk_async", 32'(SCLK), 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_lft_ld", 32'(lft_ld), 32'h0);
    chk("abort_batt", 32'(batt), 32'h0);
    ch_val[0] = 12'hE01;
    issue(0, 12'hE01, 16'h0000);
    drain(1500);
    repeat (20) @(posedge clk);
    #1;
    chk("cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
